// File: rtl/nn_train_ctrl.sv
// nn_train_ctrl: training sequencer for the backprop network weight registers.
// Walks INIT -> (FWD -> BWD -> UPD) per sample, repeats per epoch, then
// pulses done. Drives the shared initial-load / update selects of all weight
// registers plus the forward/backward phase enables.
// Optional build macro: TRAIN_EARLY_STOP_EN (ends the run at the end of an
// epoch when err_below is high and raises the sticky early_stop flag).

// Simulation-only checks: legal parameters and mutually exclusive selects.
module nn_train_ctrl_chk #(
  parameter int FWD_CYCLES = 4,
  parameter int BWD_CYCLES = 4,
  parameter int N_SAMPLES  = 4,
  parameter int N_EPOCHS   = 1000,
  parameter int SW         = 2,
  parameter int EW         = 16
) (
  input logic clk,
  input logic reset,
  input logic select_initial,
  input logic select_update,
  input logic fwd_en,
  input logic bwd_en
);

  // Check parameter ranges and one-hot-or-zero datapath controls each cycle
  always @(posedge clk) begin
    if (reset) begin
      assert (FWD_CYCLES >= 1 && BWD_CYCLES >= 1 && N_SAMPLES >= 1 && N_EPOCHS >= 1);
      assert (N_SAMPLES <= (1 << SW));
      assert (longint'(N_EPOCHS) < (longint'(1) << EW));
      assert ($onehot0({select_initial, select_update, fwd_en, bwd_en}));
    end
  end

endmodule

module nn_train_ctrl #(
  parameter int FWD_CYCLES = 4,
  parameter int BWD_CYCLES = 4,
  parameter int N_SAMPLES  = 4,
  parameter int N_EPOCHS   = 1000,
  parameter int SW         = 2,
  parameter int EW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          err_below,
  output logic          select_initial,
  output logic          select_update,
  output logic          fwd_en,
  output logic          bwd_en,
  output logic [SW-1:0] sample_idx,
  output logic [EW-1:0] epoch_cnt,
  output logic          busy,
  output logic          done,
  output logic          early_stop
);

  // Phase counter covers the longer of the two timed phases.
  localparam int CMAX = (FWD_CYCLES > BWD_CYCLES) ? FWD_CYCLES : BWD_CYCLES;
  localparam int PW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [PW-1:0] FWD_LAST    = PW'(FWD_CYCLES - 1);
  localparam logic [PW-1:0] BWD_LAST    = PW'(BWD_CYCLES - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(N_SAMPLES - 1);
  localparam logic [EW-1:0] EPOCH_END   = EW'(N_EPOCHS);
  localparam logic [EW-1:0] EPOCH_MAX   = {EW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_FWD  = 3'd2,
    ST_BWD  = 3'd3,
    ST_UPD  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   phase_r, phase_s;
  logic [SW-1:0]   sample_r, sample_s;
  logic [EW-1:0]   epoch_r, epoch_s;
  logic [EW-1:0]   epoch_inc_s;
  logic            stop_r, stop_s;
  logic            stop_hit_s;
  logic            sel_init_r, sel_upd_r, fwd_r, bwd_r, busy_r, done_r;

`ifdef TRAIN_EARLY_STOP_EN
  assign stop_hit_s = err_below;
`else
  // err_below has no function in this build; keep it visibly consumed.
  logic unused_err_s;
  assign unused_err_s = err_below;
  assign stop_hit_s   = 1'b0;
`endif

  // Saturating epoch increment so the counter can never wrap to zero.
  assign epoch_inc_s = (epoch_r == EPOCH_MAX) ? epoch_r : (epoch_r + EW'(1));

  // Next-state and counter update logic; abort overrides every transition
  always_comb begin
    state_s  = state_r;
    phase_s  = phase_r;
    sample_s = sample_r;
    epoch_s  = epoch_r;
    stop_s   = stop_r;
    if (abort && (state_r != ST_IDLE)) begin
      // Counters keep their values so the host can see where the run stopped.
      state_s = ST_IDLE;
      phase_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s  = ST_INIT;
            phase_s  = '0;
            sample_s = '0;
            epoch_s  = '0;
            stop_s   = 1'b0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_INIT: begin
          state_s = ST_FWD;
          phase_s = '0;
        end
        ST_FWD: begin
          if (phase_r == FWD_LAST) begin
            state_s = ST_BWD;
            phase_s = '0;
          end else begin
            phase_s = phase_r + PW'(1);
          end
        end
        ST_BWD: begin
          if (phase_r == BWD_LAST) begin
            state_s = ST_UPD;
            phase_s = '0;
          end else begin
            phase_s = phase_r + PW'(1);
          end
        end
        ST_UPD: begin
          phase_s = '0;
          if (sample_r != SAMPLE_LAST) begin
            sample_s = sample_r + SW'(1);
            state_s  = ST_FWD;
          end else begin
            sample_s = '0;
            epoch_s  = epoch_inc_s;
            if (stop_hit_s) begin
              state_s = ST_DONE;
              stop_s  = 1'b1;
            end else if (epoch_inc_s == EPOCH_END) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_FWD;
            end
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
          phase_s = '0;
        end
      endcase
    end
  end

  // State, counters and Moore outputs decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      phase_r    <= '0;
      sample_r   <= '0;
      epoch_r    <= '0;
      stop_r     <= 1'b0;
      sel_init_r <= 1'b0;
      sel_upd_r  <= 1'b0;
      fwd_r      <= 1'b0;
      bwd_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      phase_r    <= phase_s;
      sample_r   <= sample_s;
      epoch_r    <= epoch_s;
      stop_r     <= stop_s;
      sel_init_r <= (state_s == ST_INIT);
      sel_upd_r  <= (state_s == ST_UPD);
      fwd_r      <= (state_s == ST_FWD);
      bwd_r      <= (state_s == ST_BWD);
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_DONE);
    end
  end

  assign select_initial = sel_init_r;
  assign select_update  = sel_upd_r;
  assign fwd_en         = fwd_r;
  assign bwd_en         = bwd_r;
  assign sample_idx     = sample_r;
  assign epoch_cnt      = epoch_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign early_stop     = stop_r;

  nn_train_ctrl_chk #(
    .FWD_CYCLES (FWD_CYCLES),
    .BWD_CYCLES (BWD_CYCLES),
    .N_SAMPLES  (N_SAMPLES),
    .N_EPOCHS   (N_EPOCHS),
    .SW         (SW),
    .EW         (EW)
  ) u_chk (
    .clk            (clk),
    .reset          (reset),
    .select_initial (sel_init_r),
    .select_update  (sel_upd_r),
    .fwd_en         (fwd_r),
    .bwd_en         (bwd_r)
  );

endmodule

// File: doc/nn_train_ctrl.md
Name: nn_train_ctrl

Overview:
Training sequencer for the backpropagation network's weight registers. The weight registers (w1_xx, w2_xx) have an initial-load select and an update select. This block generates both selects for all weight registers in common.
- Steps the datapath through init, forward, backward and update phases.
- Repeats per sample and per epoch, then reports done.
- Sits between the top-level host handshake and the weight/neuron datapath.

Parameters:
FWD_CYCLES, 4, cycles spent in forward phase per sample (>=1)
BWD_CYCLES, 4, cycles spent in backward/delta phase per sample (>=1)
N_SAMPLES, 4, training samples per epoch (>=1; XOR set = 4)
N_EPOCHS, 1000, epochs to run (>=1)
SW, 2, width of sample_idx
EW, 16, width of epoch_cnt

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin training; sampled only in IDLE
abort  in  1  synchronous abort; highest priority after reset
err_below  in  1  level from error comparator; used only with TRAIN_EARLY_STOP_EN
select_initial  out  1  to all weight registers: load initial value
select_update  out  1  to all weight registers: add delta weight
fwd_en  out  1  forward-phase enable to neuron datapath
bwd_en  out  1  backward-phase enable to delta datapath
sample_idx  out  SW  current sample index, selects input/target pair
epoch_cnt  out  EW  completed-epoch count
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion
early_stop  out  1  sticky flag: run ended by threshold

Behaviour:
- All outputs registered (Moore, decoded from next state). On reset low, asynchronously:
  - state=IDLE
  - all 1-bit outputs 0
  - sample_idx=0, epoch_cnt=0, phase counter 0
- States: IDLE, INIT, FWD, BWD, UPD, DONE.
- IDLE: start=1 -> INIT next cycle. Clears sample_idx, epoch_cnt, early_stop at the same edge.
- INIT: 1 cycle, select_initial=1 -> FWD.
- FWD: fwd_en=1 for exactly FWD_CYCLES cycles -> BWD.
- BWD: bwd_en=1 for exactly BWD_CYCLES cycles -> UPD.
- UPD: 1 cycle, select_update=1. Leaving UPD:
  - sample_idx != N_SAMPLES-1 -> sample_idx+1, to FWD.
  - Otherwise sample_idx wraps to 0 and epoch_cnt+1. If the new epoch_cnt == N_EPOCHS -> DONE, else FWD.
- DONE: 1 cycle, done=1 -> IDLE. epoch_cnt and sample_idx hold their final values until the next start.
- Latency: start sampled at edge k gives INIT at k+1 and first FWD at k+2. Each sample occupies FWD_CYCLES+BWD_CYCLES+1 cycles.
- select_initial, select_update, fwd_en and bwd_en are mutually exclusive (one-hot or all zero).
- start while busy: ignored.
- abort=1 in any non-IDLE state -> IDLE next cycle:
  - no select_update and no done pulse issued;
  - counters hold;
  - abort in IDLE has no effect.
- Simultaneous abort and a transition into UPD: abort wins, no update issued.
- Reset mid-operation: immediate return to reset values. Weight registers are not touched by this block.
- epoch_cnt saturates at 2^EW-1 (cannot occur if N_EPOCHS < 2^EW; parameter check assertion in simulation).

Optional Feature:
TRAIN_EARLY_STOP_EN
- Defined: in UPD of the last sample of an epoch, if err_below=1, go to DONE regardless of epoch_cnt. epoch_cnt is still incremented, and early_stop is set to 1 until the next start or reset.
- Undefined: err_below ignored; early_stop tied to 0; termination only at N_EPOCHS.

Test Plan:
- Reset/idle: assert reset low mid-FWD -> all outputs 0, state IDLE within the same cycle. Release, no start -> outputs stay 0 for 20 cycles.
- Single run, FWD=3, BWD=2, N_SAMPLES=1, N_EPOCHS=1; start at edge 0 -> select_initial at cycle 1, fwd_en cycles 2-4, bwd_en 5-6, select_update 7, done 8, busy low at 9, epoch_cnt=1.
- Wrap: N_SAMPLES=4, N_EPOCHS=3 -> sample_idx sequence 0,1,2,3,0,... over 12 select_update pulses. epoch_cnt increments after each 4th update; done after 12th update; exactly one select_initial.
- Abort: abort pulse during the last BWD cycle of sample 2 -> no select_update, IDLE next cycle, done never pulses; a new start re-issues select_initial and restarts at sample 0.
- Start while busy: pulse start during FWD -> no extra select_initial, sequence timing unchanged.
- TRAIN_EARLY_STOP_EN defined, N_EPOCHS=1000, err_below=1 from epoch 5 -> done after 5th epoch's last update, epoch_cnt=5, early_stop=1. Undefined -> runs to epoch_cnt=1000, early_stop=0.
